// File: rtl/keypad_col_capture_pkg.sv
// -----------------------------------------------------------------------------
// keypad_col_capture_pkg
//   Shared definitions for the keypad column input port. The row-drive output
//   port decodes the same 4-word register window, so the address constants
//   live here rather than in either block.
//
//   Contents:
//     ADDR_W / DATA_W      bus address and data widths
//     ADDR_DATA .. ADDR_EDGE_CAPTURE  register word addresses
//     COLS_DEFAULT         default number of keypad columns
// -----------------------------------------------------------------------------
package keypad_col_capture_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA         = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS       = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK     = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAPTURE = 2'd3;

  localparam int COLS_DEFAULT = 4;

endpackage : keypad_col_capture_pkg

// File: rtl/keypad_col_capture_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
//   One keypad column: two-flop synchroniser, stability counter and debounced
//   level flop. A level change is accepted only after the synchronised pin has
//   disagreed with the debounced level for DEBOUNCE_CYCLES consecutive cycles.
//
//   Ports:
//     clk      in   system clock
//     reset_n  in   synchronous active-low reset
//     pin_i    in   raw column pin (active-low, idle 1)
//     level_o  out  debounced column level
//     fall_o   out  one-cycle pulse, registered, after a debounced 1->0 change
// -----------------------------------------------------------------------------
module keypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             fall_q,  fall_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Counter runs only while the synchronised pin disagrees with the debounced
  // level; any agreement (a bounce back) restarts qualification from zero.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    fall_d = level_q & ~level_d;
  end

  // Idle level of a pulled-up column is 1, so the sync chain and the debounced
  // flop reset to "released" and no spurious press is seen out of reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule : keypad_debounce

// File: rtl/keypad_col_capture.sv
// -----------------------------------------------------------------------------
// keypad_col_capture
//   Avalon-MM input-port slave for the keypad column lines. Each column is
//   synchronised and debounced; debounced presses (1->0) latch into a W1C
//   edge-capture register that drives a maskable level interrupt.
//
//   Registers (unused high bits read 0):
//     0 DATA          RO   debounced column levels
//     1 STATUS        RO   bit0 = any key pressed
//     2 IRQ_MASK      RW   per-column interrupt enable
//     3 EDGE_CAPTURE  W1C  latched press events
//
//   Ports:
//     clk, reset_n    clock, synchronous active-low reset
//     address         register word address
//     chipselect      slave select
//     write_n         active-low write strobe
//     writedata       write data
//     in_port         raw column pins, active-low
//     readdata        combinational read data
//     irq             active-high level interrupt
// -----------------------------------------------------------------------------
module keypad_col_capture
  import keypad_col_capture_pkg::*;
#(
  parameter int COLS            = COLS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  input  logic [COLS-1:0]   in_port,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);

  logic [COLS-1:0] level;
  logic [COLS-1:0] fall;
  logic [COLS-1:0] irq_mask_q, irq_mask_d;
  logic [COLS-1:0] edge_q,     edge_d;
  logic            wr_en;
  logic            unused_wdata;

  for (genvar i = 0; i < COLS; i++) begin : g_col
    keypad_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (in_port[i]),
      .level_o (level[i]),
      .fall_o  (fall[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  // High writedata bits beyond COLS carry no meaning for this port.
  assign unused_wdata = ^writedata;

  always_comb begin
    irq_mask_d = irq_mask_q;
    edge_d     = edge_q;
    if (wr_en && address == ADDR_IRQ_MASK) begin
      irq_mask_d = writedata[COLS-1:0];
    end
    if (wr_en && address == ADDR_EDGE_CAPTURE) begin
      edge_d = edge_q & ~writedata[COLS-1:0];
    end
    // Applied after the clear so a press landing in the same cycle as its W1C
    // is kept rather than lost.
    edge_d = edge_d | fall;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edge_q     <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_q     <= edge_d;
    end
  end

  assign irq = |(edge_q & irq_mask_q);

  // Zero-wait-state read path, decoded from address alone; reads have no side
  // effects so chipselect does not need to qualify it.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:         readdata[COLS-1:0] = level;
      ADDR_STATUS:       readdata[0]        = ~&level;
      ADDR_IRQ_MASK:     readdata[COLS-1:0] = irq_mask_q;
      ADDR_EDGE_CAPTURE: readdata[COLS-1:0] = edge_q;
      default:           readdata           = '0;
    endcase
  end

endmodule : keypad_col_capture

// File: doc/keypad_col_capture.md
# keypad_col_capture

Avalon-MM input-port slave that reads the keypad column lines, the return path of the row-drive output port. Synchronises and debounces each column and latches key-press edges. Raises a maskable interrupt, so software can scan rows without polling raw, bouncing pins. Sits on the same system bus as the row port, with the same 4-word register window.

## Interface
- COLS, 4: number of column inputs; 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable clk cycles required to accept a level change (1 ms at 50 MHz); ≥ 2.
- CNT_W, 16: debounce counter width; 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- address  in  2  word address of register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- in_port  in  COLS  raw column pins; active-low with pull-ups, so 0 means a key is pressed in the driven row.
- readdata  out  32  read data, combinational from address.
- irq  out  1  level interrupt, active-high.

## Operation
- **Synchroniser:** 2-flop per column on in_port. Reset value is all 1s (released).
- **Debounce, per column:**
  - Counter resets to 0 whenever the synchronised bit equals the debounced bit.
  - Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced bit takes the synchronised value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is rejected.
- **Press detect:** debounced 1→0 transition sets edge_capture[i]. Release (0→1) never sets a bit.
- **Registers** (unused high bits read 0):
  - 0 DATA, RO: debounced column levels.
  - 1 STATUS, RO: bit0 = any key pressed (~&debounced); bits[COLS:1] reserved 0.
  - 2 IRQ_MASK, RW: COLS bits; only a write with address 2 updates it.
  - 3 EDGE_CAPTURE, W1C: writing 1 to bit i clears bit i; writing 0 has no effect.
- Writes to addresses 0 and 1 are ignored.
- irq = |(edge_capture & irq_mask).
- **Reset values:**
  - sync flops, debounced: all 1s.
  - counters, edge_capture, irq_mask: 0.
  - irq: 0.
  - readdata at address 0 after reset: 2^COLS-1.
- **Simultaneous events:**
  - Set and W1C on the same bit in the same cycle: set wins, bit stays 1.
  - Presses on several columns in the same cycle set all corresponding bits.
- **Reset mid-debounce:** counters and all state return to reset values on the next clk edge. No edge is captured for a press in progress; it must re-qualify from zero.

## Timing
- A level change on in_port before edge k reaches the second sync flop at edge k+1.
- The debounced bit changes at edge k+1+DEBOUNCE_CYCLES, if the new level is held throughout.
- edge_capture[i] and irq assert at edge k+2+DEBOUNCE_CYCLES.
- readdata is zero-wait-state: valid in the same cycle as address/chipselect.
- Register writes take effect at the next clk edge. irq deasserts the cycle after a W1C of the last unmasked set bit, or after a mask clear.
- No read side effects.

## Structure
- **Shared package:** register address constants (DATA=0, STATUS=1, IRQ_MASK=2, EDGE_CAPTURE=3) and COLS_DEFAULT. The row output port uses the same address map.
- **Sub-module keypad_debounce:** one column, containing the 2-flop sync, counter and debounced flop. Parameters DEBOUNCE_CYCLES and CNT_W; outputs the level plus a one-cycle fall pulse. Instantiated COLS times via generate.
- **Top level:** register file, W1C logic, read mux and irq.

## Test plan
Run with DEBOUNCE_CYCLES=4.
- **Reset:** hold reset_n=0 for 3 cycles with in_port=4'b0000 → DATA reads 4'hF, EDGE_CAPTURE reads 0, irq=0.
- **Clean press on column 2:** in_port=4'b1011 held → DATA=4'b1011 at edge 5, EDGE_CAPTURE=4'b0100 at edge 6. irq stays 0 with mask 0; write IRQ_MASK=4'h4 → irq=1 next cycle.
- **Bounce rejection:** col 0 toggles low for 3 cycles, high for 1, repeatedly → DATA stays 4'hF, no edge captured. Then hold low 6 cycles → DATA=4'b1110, EDGE_CAPTURE bit0=1.
- **W1C:**
  - EDGE_CAPTURE=4'b0101, write 4'b0001 → reads 4'b0100.
  - Write 4'b0000 → unchanged.
  - Release col 2 → no new bit set.
- **Collision:** W1C of bit 1 in the same cycle col 1's debounced fall occurs → bit 1 reads 1, irq stays 1 if mask bit 1 set.
- **Reset mid-debounce:** col 3 low for 2 cycles, pulse reset_n=0 for 1 cycle, keep col 3 low → DATA bit3 goes 0 only 5 edges after reset release; edge bit3 set once.
